// File: rtl/sched_pkg.sv
// Shared constants and types for the preemptive round-robin quantum scheduler.
package sched_pkg;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_QUANTUM = 2'd1;
  localparam logic [1:0] CAUSE_IO      = 2'd2;
  localparam logic [1:0] CAUSE_END     = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    REQ  = 2'd2
  } sched_state_t;

  // The saved PC lives in a parallel array because its width is a module parameter.
  typedef struct packed {
    logic valid;
    logic blocked;
  } proc_entry_t;

  function automatic int pid_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int q);
    return (q > 1) ? $clog2(q) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority picker: first eligible index at or after start, wrapping
// modulo N, so the entry just before start is considered last.
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] pid
);

  localparam int unsigned NU = N;

  function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    sum = (sum >= NU) ? (sum - NU) : sum;
    return sum[W-1:0];
  endfunction

  // Scan N slots from start and latch the first eligible one.
  always_comb begin
    valid = 1'b0;
    pid   = {W{1'b0}};
    for (int unsigned i = 0; i < NU; i++) begin
      if (!valid && eligible[wrap_idx(start, i)]) begin
        valid = 1'b1;
        pid   = wrap_idx(start, i);
      end else begin
        pid = pid;
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// N-process preemptive round-robin scheduler: counts user retirements per slice,
// raises context-switch requests and keeps a saved-PC / ready table per process.
module quantum_scheduler
  import sched_pkg::*;
#(
  parameter int QUANTUM     = 5,
  parameter int PC_WIDTH    = 32,
  parameter int N_PROC      = 4,
  parameter int OS_PC_LIMIT = 300,
  localparam int PID_W      = pid_width(N_PROC)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                instr_valid,
  input  logic                io_instr,
  input  logic                proc_end,
  input  logic                create_en,
  input  logic [PID_W-1:0]    create_pid,
  input  logic [PC_WIDTH-1:0] create_pc,
  input  logic                io_done,
  input  logic [PID_W-1:0]    io_done_pid,
  input  logic                ctx_ack,
  output logic                ctx_switch,
  output logic [1:0]          switch_cause,
  output logic [PC_WIDTH-1:0] saved_pc,
  output logic [PID_W-1:0]    saved_pid,
  output logic                next_valid,
  output logic [PID_W-1:0]    next_pid,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic [PID_W-1:0]    current_pid
);

  localparam int                  CNT_W    = count_width(QUANTUM);
  localparam logic [CNT_W-1:0]    Q_LAST   = CNT_W'(QUANTUM - 1);
  localparam logic [PC_WIDTH-1:0] OS_LIMIT = PC_WIDTH'(OS_PC_LIMIT);
  localparam logic [PID_W-1:0]    LAST_PID = PID_W'(N_PROC - 1);

  sched_state_t        state_r;
  sched_state_t        state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [1:0]          cause_r;
  logic [PC_WIDTH-1:0] saved_pc_r;
  logic [PID_W-1:0]    saved_pid_r;
  logic [PID_W-1:0]    cur_pid_r;
  proc_entry_t         entry_r  [N_PROC];
  logic [PC_WIDTH-1:0] tbl_pc_r [N_PROC];

  logic                counted_s;
  logic                trigger_s;
  logic                ack_s;
  logic                take_s;
  logic [1:0]          cause_s;
  logic [PC_WIDTH-1:0] pc_inc_s;
  logic [N_PROC-1:0]   elig_s;
  logic [PID_W-1:0]    start_s;
  logic                pick_valid_s;
  logic [PID_W-1:0]    pick_pid_s;

  // Retirement qualification and switch trigger with end > I/O > quantum priority.
  always_comb begin
    pc_inc_s  = pc + PC_WIDTH'(1'b1);
    counted_s = (state_r == RUN) && instr_valid && (pc > OS_LIMIT);
    trigger_s = counted_s && (proc_end || io_instr || (cnt_r == Q_LAST));
    ack_s     = ctx_ack && ((state_r == IDLE) || (state_r == REQ));
    take_s    = ack_s && pick_valid_s;
    if (proc_end) begin
      cause_s = CAUSE_END;
    end else if (io_instr) begin
      cause_s = CAUSE_IO;
    end else begin
      cause_s = CAUSE_QUANTUM;
    end
  end

  // Eligibility mask and scan start just after the current process.
  always_comb begin
    elig_s = {N_PROC{1'b0}};
    for (int i = 0; i < N_PROC; i++) begin
      elig_s[i] = entry_r[i].valid && !entry_r[i].blocked;
    end
    if (cur_pid_r == LAST_PID) begin
      start_s = {PID_W{1'b0}};
    end else begin
      start_s = cur_pid_r + PID_W'(1'b1);
    end
  end

  rr_picker #(
    .N (N_PROC),
    .W (PID_W)
  ) u_picker (
    .eligible (elig_s),
    .start    (start_s),
    .valid    (pick_valid_s),
    .pid      (pick_pid_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (trigger_s) begin
          state_s = REQ;
        end else begin
          state_s = RUN;
        end
      end
      REQ: begin
        if (!ack_s) begin
          state_s = REQ;
        end else if (pick_valid_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Slice counter, running pid and the switch record handed to the OS.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      cause_r     <= CAUSE_NONE;
      saved_pc_r  <= {PC_WIDTH{1'b0}};
      saved_pid_r <= {PID_W{1'b0}};
      cur_pid_r   <= {PID_W{1'b0}};
    end else if (trigger_s) begin
      cnt_r       <= {CNT_W{1'b0}};
      cause_r     <= cause_s;
      saved_pc_r  <= pc_inc_s;
      saved_pid_r <= cur_pid_r;
    end else if (counted_s) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else if (ack_s) begin
      cause_r <= CAUSE_NONE;
      if (take_s) begin
        cur_pid_r <= pick_pid_s;
        cnt_r     <= {CNT_W{1'b0}};
      end else begin
        cur_pid_r <= cur_pid_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Process table; a trigger owns the current entry, create beats io_done.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_PROC; i++) begin
        entry_r[i]  <= '{valid: 1'b0, blocked: 1'b0};
        tbl_pc_r[i] <= {PC_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_PROC; i++) begin
        if (trigger_s && (cur_pid_r == PID_W'(i))) begin
          case (cause_s)
            CAUSE_END: entry_r[i].valid <= 1'b0;
            CAUSE_IO: begin
              entry_r[i].blocked <= 1'b1;
              tbl_pc_r[i]        <= pc_inc_s;
            end
            default: tbl_pc_r[i] <= pc_inc_s;
          endcase
        end else if (create_en && (create_pid == PID_W'(i)) &&
                     !((state_r == RUN) && (cur_pid_r == PID_W'(i)))) begin
          entry_r[i]  <= '{valid: 1'b1, blocked: 1'b0};
          tbl_pc_r[i] <= create_pc;
        end else if (io_done && (io_done_pid == PID_W'(i)) && entry_r[i].valid) begin
          entry_r[i].blocked <= 1'b0;
        end else begin
          entry_r[i] <= entry_r[i];
        end
      end
    end
  end

  assign ctx_switch   = (state_r == REQ);
  assign switch_cause = cause_r;
  assign saved_pc     = saved_pc_r;
  assign saved_pid    = saved_pid_r;
  assign current_pid  = cur_pid_r;
  assign next_valid   = pick_valid_s;
  assign next_pid     = pick_pid_s;
  assign next_pc      = pick_valid_s ? tbl_pc_r[pick_pid_s] : {PC_WIDTH{1'b0}};

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed bench for quantum_scheduler with a behavioural table model checked every cycle.
module tb_quantum_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'd0;
  logic        instr_valid = 1'b0;
  logic        io_instr = 1'b0;
  logic        proc_end = 1'b0;
  logic        create_en = 1'b0;
  logic [1:0]  create_pid = 2'd0;
  logic [31:0] create_pc = 32'd0;
  logic        io_done = 1'b0;
  logic [1:0]  io_done_pid = 2'd0;
  logic        ctx_ack = 1'b0;
  logic        ctx_switch;
  logic [1:0]  switch_cause;
  logic [31:0] saved_pc;
  logic [1:0]  saved_pid;
  logic        next_valid;
  logic [1:0]  next_pid;
  logic [31:0] next_pc;
  logic [1:0]  current_pid;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  quantum_scheduler #(
    .QUANTUM(5), .PC_WIDTH(32), .N_PROC(4), .OS_PC_LIMIT(300)
  ) dut (
    .clock(clock), .reset(reset), .pc(pc), .instr_valid(instr_valid),
    .io_instr(io_instr), .proc_end(proc_end), .create_en(create_en),
    .create_pid(create_pid), .create_pc(create_pc), .io_done(io_done),
    .io_done_pid(io_done_pid), .ctx_ack(ctx_ack), .ctx_switch(ctx_switch),
    .switch_cause(switch_cause), .saved_pc(saved_pc), .saved_pid(saved_pid),
    .next_valid(next_valid), .next_pid(next_pid), .next_pc(next_pc),
    .current_pid(current_pid)
  );

  always #5 clock = ~clock;

  // Model: "running" = slice in progress, "requesting" = waiting for the OS.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_REQ  = 2;

  bit          m_valid [4];
  bit          m_blk   [4];
  logic [31:0] m_pc    [4];
  int          m_mode, m_cnt, m_cur, m_spid;
  logic [1:0]  m_cause;
  logic [31:0] m_spc;
  bit          mv_nv, mv_counted, mv_fire;
  int          mv_np;

  function automatic void model_pick(output bit v, output int p);
    v = 1'b0;
    p = 0;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_cur + k) % 4;
      if (!v && m_valid[idx] && !m_blk[idx]) begin
        v = 1'b1;
        p = idx;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_mode = M_IDLE; m_cnt = 0; m_cur = 0; m_spid = 0; m_cause = 2'd0; m_spc = 32'd0;
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 1'b0; m_blk[i] = 1'b0; m_pc[i] = 32'd0;
      end
    end else begin
      model_pick(mv_nv, mv_np);
      mv_counted = (m_mode == M_RUN) && instr_valid && (pc > 32'd300);
      mv_fire = mv_counted && (proc_end || io_instr || (m_cnt + 1 == 5));
      if (io_done && m_valid[io_done_pid]) m_blk[io_done_pid] = 1'b0;
      if (create_en && !(m_mode == M_RUN && int'(create_pid) == m_cur)) begin
        m_valid[create_pid] = 1'b1; m_blk[create_pid] = 1'b0; m_pc[create_pid] = create_pc;
      end
      if (mv_fire) begin
        if (proc_end) begin
          m_valid[m_cur] = 1'b0; m_cause = 2'd3;
        end else if (io_instr) begin
          m_blk[m_cur] = 1'b1; m_pc[m_cur] = pc + 32'd1; m_cause = 2'd2;
        end else begin
          m_pc[m_cur] = pc + 32'd1; m_cause = 2'd1;
        end
        m_spc = pc + 32'd1; m_spid = m_cur; m_cnt = 0; m_mode = M_REQ;
      end else if (mv_counted) begin
        m_cnt = m_cnt + 1;
      end else if (ctx_ack && m_mode != M_RUN) begin
        m_cause = 2'd0;
        if (mv_nv) begin
          m_cur = mv_np; m_cnt = 0; m_mode = M_RUN;
        end else begin
          m_mode = M_IDLE;
        end
      end
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clock) begin
    bit v;
    int p;
    if (chk_en) begin
      model_pick(v, p);
      chk("cmp_ctx_switch", 32'(ctx_switch), 32'(m_mode == M_REQ));
      chk("cmp_switch_cause", 32'(switch_cause), 32'(m_cause));
      chk("cmp_saved_pc", saved_pc, m_spc);
      chk("cmp_saved_pid", 32'(saved_pid), 32'(m_spid));
      chk("cmp_current_pid", 32'(current_pid), 32'(m_cur));
      chk("cmp_next_valid", 32'(next_valid), 32'(v));
      chk("cmp_next_pid", 32'(next_pid), 32'(p));
      chk("cmp_next_pc", next_pc, v ? m_pc[p] : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic retire(input logic [31:0] p, input bit io, input bit en);
    pc = p; instr_valid = 1'b1; io_instr = io; proc_end = en;
    tick();
    instr_valid = 1'b0; io_instr = 1'b0; proc_end = 1'b0;
  endtask

  task automatic create(input int pid, input logic [31:0] p);
    create_en = 1'b1; create_pid = 2'(pid); create_pc = p;
    tick();
    create_en = 1'b0;
  endtask

  task automatic ack();
    ctx_ack = 1'b1;
    tick();
    ctx_ack = 1'b0;
  endtask

  task automatic unblock(input int pid);
    io_done = 1'b1; io_done_pid = 2'(pid);
    tick();
    io_done = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk_en = 1'b1;
    reset = 1'b0;
    chk("rst_ctx_switch", 32'(ctx_switch), 32'd0);
    chk("rst_next_valid", 32'(next_valid), 32'd0);
    chk("rst_current_pid", 32'(current_pid), 32'd0);

    // Quantum expiry on pid0, pid1 waiting.
    create(0, 32'd400); tick();
    chk("create_next_pc", next_pc, 32'd400);
    ack();
    create(1, 32'd500); tick();
    for (int i = 0; i < 4; i++) retire(32'd400 + 32'(i), 1'b0, 1'b0);
    chk("q_not_yet", 32'(ctx_switch), 32'd0);
    retire(32'd404, 1'b0, 1'b0);
    chk("q_switch", 32'(ctx_switch), 32'd1);
    chk("q_cause", 32'(switch_cause), 32'd1);
    chk("q_saved_pc", saved_pc, 32'd405);
    tick();
    chk("q_next_pid", 32'(next_pid), 32'd1);
    chk("q_next_pc", next_pc, 32'd500);

    // I/O block on pid1, with a simultaneous io_done that must lose.
    ack();
    retire(32'd500, 1'b0, 1'b0);
    retire(32'd501, 1'b0, 1'b0);
    io_done = 1'b1; io_done_pid = 2'd1;
    retire(32'd502, 1'b1, 1'b0);
    io_done = 1'b0;
    chk("io_cause", 32'(switch_cause), 32'd2);
    chk("io_saved_pc", saved_pc, 32'd503);
    tick();
    chk("io_next_pid", 32'(next_pid), 32'd0);
    chk("io_next_pc", next_pc, 32'd405);
    ack();
    unblock(1); tick();
    chk("unblock_next_pid", 32'(next_pid), 32'd1);

    // OS-range retirements never count; a stray ack in RUN is ignored.
    ctx_ack = 1'b1;
    for (int i = 0; i < 10; i++) retire(32'd250, 1'b0, 1'b0);
    ctx_ack = 1'b0;
    chk("os_no_switch", 32'(ctx_switch), 32'd0);
    for (int i = 0; i < 4; i++) retire(32'd405 + 32'(i), 1'b0, 1'b0);
    chk("os_count_4", 32'(ctx_switch), 32'd0);
    retire(32'd409, 1'b0, 1'b0);
    chk("os_count_5", 32'(ctx_switch), 32'd1);
    retire(32'd600, 1'b0, 1'b0);
    retire(32'd601, 1'b1, 1'b0);
    chk("req_saved_hold", saved_pc, 32'd410);

    // End beats I/O on the 5th retirement.
    ack();
    for (int i = 0; i < 4; i++) retire(32'd503 + 32'(i), 1'b0, 1'b0);
    retire(32'd507, 1'b1, 1'b1);
    chk("end_cause", 32'(switch_cause), 32'd3);
    chk("end_saved_pc", saved_pc, 32'd508);

    // Wrap-around and self re-selection.
    ack();
    create(3, 32'd700);
    for (int i = 0; i < 5; i++) retire(32'd410 + 32'(i), 1'b0, 1'b0);
    tick();
    chk("wrap_next_pid3", 32'(next_pid), 32'd3);
    ack(); tick();
    chk("wrap_next_pid0", 32'(next_pid), 32'd0);
    for (int i = 0; i < 5; i++) retire(32'd700 + 32'(i), 1'b0, 1'b0);
    ack();
    retire(32'd415, 1'b1, 1'b0);
    ack();
    for (int i = 0; i < 5; i++) retire(32'd705 + 32'(i), 1'b0, 1'b0);
    tick();
    chk("self_next_pid", 32'(next_pid), 32'd3);
    chk("self_next_pc", next_pc, 32'd710);

    // Reset while a switch is pending.
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rreq_ctx_switch", 32'(ctx_switch), 32'd0);
    chk("rreq_saved_pc", saved_pc, 32'd0);
    chk("rreq_next_valid", 32'(next_valid), 32'd0);
    chk("rreq_next_pc", next_pc, 32'd0);

    // Last process ends, back to IDLE; create beats io_done; create on running pid ignored.
    io_done = 1'b1; io_done_pid = 2'd1;
    create(2, 32'd600);
    io_done = 1'b0;
    ack();
    retire(32'd600, 1'b0, 1'b1);
    tick();
    chk("last_next_valid", 32'(next_valid), 32'd0);
    ack();
    chk("idle_ctx_switch", 32'(ctx_switch), 32'd0);
    chk("idle_cause", 32'(switch_cause), 32'd0);
    retire(32'd601, 1'b0, 1'b0);
    io_done = 1'b1; io_done_pid = 2'd1;
    create(1, 32'd800);
    io_done = 1'b0;
    tick();
    chk("cw_next_pc", next_pc, 32'd800);
    ack();
    chk("run_current_pid", 32'(current_pid), 32'd1);
    create(1, 32'd900);
    for (int i = 0; i < 5; i++) retire(32'd800 + 32'(i), 1'b0, 1'b0);
    tick();
    chk("ign_create_next_pc", next_pc, 32'd805);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
